pair_avg_stage: RTL

//  Streaming stage feeding the averaging datapath: pairs consecutive samples

---
 rtl/pair_avg_stage_pkg.sv | 12 +
 rtl/pair_avg_stage_if.sv | 23 ++
 rtl/pair_avg_stage_avg_add.sv | 20 ++
 rtl/pair_avg_stage.sv | 82 ++++++++
 4 files changed

// File: rtl/pair_avg_stage_pkg.sv
// Shared types and defaults for the pair-averaging stage.
package pair_avg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pair_avg_state_t;

  localparam int unsigned PAIR_AVG_W_DEF = 4;

endpackage

// File: rtl/pair_avg_stage_if.sv
// Valid/ready sample input and result output of the pair-averaging stage.
interface pair_avg_stage_if #(
  parameter int unsigned W = pair_avg_pkg::PAIR_AVG_W_DEF
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [W:0]   out_sum;

  // slave: the stage itself; master: the surrounding producer/consumer
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sum
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sum
  );
endinterface

// File: rtl/pair_avg_stage_avg_add.sv
// Combinational W+1-bit pair sum and average; PAIR_AVG_ROUND_EN selects round-half-up.
module avg_add #(
  parameter int unsigned W = pair_avg_pkg::PAIR_AVG_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum,
  output logic [W-1:0] avg
);
  assign sum = {1'b0, a} + {1'b0, b};

`ifdef PAIR_AVG_ROUND_EN
  // a+b+1 peaks at 2^(W+1)-1, so the rounded sum still fits W+1 bits
  logic [W:0] rsum;
  assign rsum = sum + {{W{1'b0}}, 1'b1};
  assign avg  = rsum[W:1];
`else
  assign avg  = sum[W:1];
`endif
endmodule

// File: rtl/pair_avg_stage.sv
// Pairs consecutive input samples and emits their average per pair.
// Build option: PAIR_AVG_ROUND_EN (round half up instead of truncate).
module pair_avg_stage
  import pair_avg_pkg::*;
#(
  parameter int unsigned W     = PAIR_AVG_W_DEF,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  pair_avg_stage_if.slave  io,
  output logic [CNT_W-1:0] pair_cnt
);
  pair_avg_state_t state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    out_data_r;
  logic [W:0]      out_sum_r;
  logic [CNT_W-1:0] cnt_r;

  logic            in_fire;
  logic            out_fire;
  logic [W:0]      sum;
  logic [W-1:0]    avg;

  avg_add #(.W(W)) u_add (
    .a   (a_reg),
    .b   (io.in_data),
    .sum (sum),
    .avg (avg)
  );

  assign io.in_ready  = rst_n & ~flush & ((state != FULL) | io.out_ready);
  assign io.out_valid = (state == FULL);
  assign io.out_data  = out_data_r;
  assign io.out_sum   = out_sum_r;
  assign pair_cnt     = cnt_r;

  assign in_fire  = io.in_valid & io.in_ready;
  assign out_fire = io.out_valid & io.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      a_reg      <= '0;
      out_data_r <= '0;
      out_sum_r  <= '0;
      cnt_r      <= '0;
    end else begin
      if (out_fire) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            a_reg <= io.in_data;
            state <= HALF;
          end
        end
        HALF: begin
          // flush forces in_ready low, so it never races a second sample
          if (flush) begin
            state <= EMPTY;
          end else if (in_fire) begin
            out_data_r <= avg;
            out_sum_r  <= sum;
            state      <= FULL;
          end
        end
        FULL: begin
          if (out_fire) begin
            if (in_fire) begin
              a_reg <= io.in_data;
              state <= HALF;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule
